// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared constants, receive state encoding and CRC-32 byte update for the RX MAC
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
  localparam logic [7:0]  ETH_SFD       = 8'hD5;
  localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
  localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

  // Oldest delay-line byte becomes payload once the 4 FCS bytes are queued behind it.
  localparam logic [2:0]  RX_DL_FULL    = 3'd5;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_PRE  = 2'd1,
    RX_DATA = 2'd2,
    RX_DROP = 2'd3
  } rx_state_e;

  function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
    logic [31:0] c;
    c = crc ^ {24'h0, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/eth_rx_fifo.sv
// rtl/eth_rx_fifo.sv - first-word-fall-through FIFO holding {err,last,data} receive beats
module eth_rx_fifo
#(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic                     rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  always_comb begin
    push     = wr_en && (count_q != FULL_COUNT);
    pop      = rd_en && (count_q != '0);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Head is forced to zero when empty so the outputs are clean during and after reset.
  assign rd_valid = (count_q != '0);
  assign rd_data  = rd_valid ? mem_q[rd_ptr_q] : '0;
  assign count    = count_q;

endmodule

// File: rtl/eth_rx_mac.sv
// rtl/eth_rx_mac.sv - receive MAC: preamble/SFD strip, CRC-32 and length check, FCS strip, payload FIFO
// Define ETH_RX_STATS_EN to add saturating stat_good/stat_err/stat_drop frame counters.
module eth_rx_mac
  import eth_pkg::*;
#(
  parameter int FIFO_DEPTH = 2048,
  parameter int MIN_FRAME  = 64,
  parameter int MAX_FRAME  = 1518
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        phy_rx_dv,
  input  logic [7:0]  phy_rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_last,
  output logic        rx_err
`ifdef ETH_RX_STATS_EN
  ,
  output logic [15:0] stat_good,
  output logic [15:0] stat_err,
  output logic [15:0] stat_drop
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] ROOM_LIMIT = CW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] FULL_LIMIT = CW'(FIFO_DEPTH);
  localparam logic [10:0]   MIN_LEN    = 11'(MIN_FRAME);
  localparam logic [10:0]   MAX_LEN    = 11'(MAX_FRAME);
  localparam logic [10:0]   LEN_SAT    = 11'h7FF;

  rx_state_e       state_q, state_d;
  logic [31:0]     crc_q, crc_d;
  logic [10:0]     len_q, len_d;
  logic            ovf_q, ovf_d;
  logic [4:0][7:0] dl_q, dl_d;
  logic [2:0]      dl_cnt_q, dl_cnt_d;

  logic            sfd_hit, data_beat, frame_end, dl_full, in_bounds, has_room, fifo_full;
  logic            frame_err, wr_en, wr_last, frame_lost;
  logic [9:0]      wr_data;
  logic [9:0]      head;
  logic [CW-1:0]   fifo_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= RX_IDLE;
      crc_q    <= CRC32_INIT;
      len_q    <= '0;
      ovf_q    <= 1'b0;
      dl_q     <= '0;
      dl_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      crc_q    <= crc_d;
      len_q    <= len_d;
      ovf_q    <= ovf_d;
      dl_q     <= dl_d;
      dl_cnt_q <= dl_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RX_IDLE: if (phy_rx_dv) state_d = (phy_rx_data == ETH_PREAMBLE) ? RX_PRE : RX_DROP;
      RX_PRE: begin
        if (!phy_rx_dv)                       state_d = RX_IDLE;
        else if (phy_rx_data == ETH_SFD)      state_d = RX_DATA;
        else if (phy_rx_data != ETH_PREAMBLE) state_d = RX_DROP;
      end
      RX_DATA: if (!phy_rx_dv) state_d = RX_IDLE;
      RX_DROP: if (!phy_rx_dv) state_d = RX_IDLE;
      default: state_d = RX_IDLE;
    endcase
  end

  always_comb begin
    sfd_hit   = (state_q == RX_PRE) && phy_rx_dv && (phy_rx_data == ETH_SFD);
    data_beat = (state_q == RX_DATA) && phy_rx_dv;
    frame_end = (state_q == RX_DATA) && !phy_rx_dv;
    dl_full   = (dl_cnt_q == RX_DL_FULL);
    // len_q counts bytes before the current one, so this caps payload at MAX_FRAME-4 beats.
    in_bounds = (len_q < MAX_LEN);
    has_room  = (fifo_count < ROOM_LIMIT);
    fifo_full = (fifo_count == FULL_LIMIT);
    frame_err = (crc_q != CRC32_RESIDUE) || (len_q < MIN_LEN) || (len_q > MAX_LEN) || ovf_q;

    wr_last    = frame_end && dl_full && !fifo_full;
    frame_lost = frame_end && dl_full && fifo_full;
    wr_en      = (data_beat && dl_full && in_bounds && has_room) || wr_last;
    wr_data    = wr_last ? {frame_err, 1'b1, dl_q[4]} : {2'b00, dl_q[4]};
  end

  always_comb begin
    crc_d    = crc_q;
    len_d    = len_q;
    ovf_d    = ovf_q;
    dl_d     = dl_q;
    dl_cnt_d = dl_cnt_q;
    if (sfd_hit) begin
      crc_d    = CRC32_INIT;
      len_d    = '0;
      ovf_d    = 1'b0;
      dl_d     = '0;
      dl_cnt_d = '0;
    end else if (data_beat) begin
      crc_d    = crc32_byte(crc_q, phy_rx_data);
      len_d    = (len_q == LEN_SAT) ? len_q : len_q + 11'd1;
      dl_d     = {dl_q[3:0], phy_rx_data};
      dl_cnt_d = dl_full ? dl_cnt_q : dl_cnt_q + 3'd1;
      if (dl_full && in_bounds && !has_room) ovf_d = 1'b1;
    end
  end

  eth_rx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (10)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (rx_ready),
    .rd_valid (rx_valid),
    .rd_data  (head),
    .count    (fifo_count)
  );

  assign rx_data = head[7:0];
  assign rx_last = head[8];
  assign rx_err  = head[9];

`ifdef ETH_RX_STATS_EN
  logic [15:0] stat_good_q, stat_good_d;
  logic [15:0] stat_err_q, stat_err_d;
  logic [15:0] stat_drop_q, stat_drop_d;
  logic        drop_enter;

  always_comb begin
    drop_enter  = (state_d == RX_DROP) && (state_q != RX_DROP);
    stat_good_d = stat_good_q;
    stat_err_d  = stat_err_q;
    stat_drop_d = stat_drop_q;
    if (wr_last && !frame_err && (stat_good_q != 16'hFFFF)) stat_good_d = stat_good_q + 16'd1;
    if (wr_last && frame_err && (stat_err_q != 16'hFFFF))   stat_err_d  = stat_err_q + 16'd1;
    if ((frame_lost || drop_enter) && (stat_drop_q != 16'hFFFF)) stat_drop_d = stat_drop_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_good_q <= '0;
      stat_err_q  <= '0;
      stat_drop_q <= '0;
    end else begin
      stat_good_q <= stat_good_d;
      stat_err_q  <= stat_err_d;
      stat_drop_q <= stat_drop_d;
    end
  end

  assign stat_good = stat_good_q;
  assign stat_err  = stat_err_q;
  assign stat_drop = stat_drop_q;
`endif

endmodule
